// File: rtl/yolo_cam_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : yolo_cam_pkg
//  Description : Shared defaults, pixel type and capture FSM state encoding
//                for the camera capture path feeding the YOLO preprocessor.
//  Revision    : 1.0  initial release
// ============================================================================
package yolo_cam_pkg;

    localparam int c_DEF_IMG_W  = 416;
    localparam int c_DEF_IMG_H  = 416;
    localparam int c_DEF_DATA_W = 24;
    localparam int c_DEF_ADDR_W = 18;

    typedef logic [c_DEF_DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    // Counter width for a range of v values, never narrower than one bit
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage : yolo_cam_pkg
`default_nettype wire

// File: rtl/capture_pixel_counter.sv
`default_nettype none
// ============================================================================
//  Module      : capture_pixel_counter
//  Description : x/y position and linear frame-buffer address counters.
//                Clear and advance may be asserted together: the result is
//                the position following pixel (0,0). The address is a running
//                counter so no multiplier is needed.
//  Revision    : 1.0  initial release
// ============================================================================
module capture_pixel_counter
    import yolo_cam_pkg::*;
#(
    parameter int IMG_W  = c_DEF_IMG_W,
    parameter int IMG_H  = c_DEF_IMG_H,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last_pixel
);

    localparam int c_XW = clog2_min1(IMG_W);
    localparam int c_YW = clog2_min1(IMG_H);
    localparam logic [c_XW-1:0] c_X_MAX = c_XW'(IMG_W - 1);
    localparam logic [c_YW-1:0] c_Y_MAX = c_YW'(IMG_H - 1);

    logic [c_XW-1:0]   r_x, w_x_base, w_x_nxt;
    logic [c_YW-1:0]   r_y, w_y_base, w_y_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_base, w_addr_nxt;

    // Next position: optionally restart from zero, then optionally step one pixel
    always_comb begin
        w_x_base    = i_clear ? '0 : r_x;
        w_y_base    = i_clear ? '0 : r_y;
        w_addr_base = i_clear ? '0 : r_addr;
        w_x_nxt     = w_x_base;
        w_y_nxt     = w_y_base;
        w_addr_nxt  = w_addr_base;
        if (i_advance) begin
            if (w_x_base == c_X_MAX) begin
                w_x_nxt = '0;
                w_y_nxt = (w_y_base == c_Y_MAX) ? '0 : w_y_base + 1'b1;
            end else begin
                w_x_nxt = w_x_base + 1'b1;
            end
            w_addr_nxt = w_addr_base + 1'b1;
        end
    end

    // Position registers; hold unless cleared or advanced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (i_clear || i_advance) begin
            r_x    <= w_x_nxt;
            r_y    <= w_y_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    assign o_addr       = r_addr;
    assign o_last_pixel = (r_x == c_X_MAX) && (r_y == c_Y_MAX);

endmodule : capture_pixel_counter
`default_nettype wire

// File: rtl/camera_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : camera_capture_ctrl
//  Description : Arms on a host command, aligns to start-of-frame, tracks the
//                pixel position and issues registered frame-buffer writes.
//                Reports frame completion, dropped pixels, stray SOFs and a
//                wrapping completed-frame count.
//  Revision    : 1.0  initial release
// ============================================================================
module camera_capture_ctrl
    import yolo_cam_pkg::*;
#(
    parameter int IMG_W  = c_DEF_IMG_W,
    parameter int IMG_H  = c_DEF_IMG_H,
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int ADDR_W = c_DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic              cam_sof,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              cam_valid,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow,
    output logic              sof_err,
    output logic [7:0]        frame_count
);

    cap_state_t        r_state, w_state_nxt;
    logic              r_cont;
    logic              w_start_ok;
    logic              w_accept;
    logic              w_restart;
    logic              w_sof_mid;
    logic              w_frame_end;
    logic              w_cnt_clear;
    logic [ADDR_W-1:0] w_cnt_addr;
    logic [ADDR_W-1:0] w_pix_addr;
    logic              w_last_pixel;

    capture_pixel_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_cnt_clear),
        .i_advance    (w_accept),
        .o_addr       (w_cnt_addr),
        .o_last_pixel (w_last_pixel)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (start) w_state_nxt = ST_ARMED;
                ST_ARMED:   if (cam_valid && cam_sof) w_state_nxt = ST_CAPTURE;
                ST_CAPTURE: if (cam_valid && !cam_sof && w_last_pixel) w_state_nxt = ST_DONE;
                ST_DONE:    w_state_nxt = r_cont ? ST_ARMED : ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Per-cycle control decoded from state and inputs
    always_comb begin
        w_start_ok  = (r_state == ST_IDLE) && start && !abort;
        w_accept    = cam_valid && !abort &&
                      (((r_state == ST_ARMED) && cam_sof) || (r_state == ST_CAPTURE));
        w_restart   = w_accept && cam_sof;
        w_sof_mid   = w_restart && (r_state == ST_CAPTURE);
        w_frame_end = (r_state == ST_DONE) && !abort;
        // Counters restart on arm, abort, frame end and on any SOF pixel
        w_cnt_clear = abort || w_start_ok || w_restart || (r_state == ST_DONE);
        // An SOF pixel is always (0,0), regardless of where the counters were
        w_pix_addr  = w_restart ? '0 : w_cnt_addr;
        busy        = (r_state != ST_IDLE);
    end

    // Continuous mode is captured only when a capture is armed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_cont <= 1'b0;
        else if (w_start_ok) r_cont <= continuous;
    end

    // Registered write port and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            sof_err     <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            wr_en      <= w_accept && wr_ready;
            if (w_accept && wr_ready) begin
                wr_addr <= w_pix_addr;
                wr_data <= cam_data;
            end
            frame_done <= w_frame_end;
            if (w_frame_end) frame_count <= frame_count + 8'd1;
            if (w_start_ok) begin
                overflow <= 1'b0;
                sof_err  <= 1'b0;
            end else begin
                // Dropped pixels still advance the counters, so geometry is kept
                if (w_accept && !wr_ready) overflow <= 1'b1;
                if (w_sof_mid)             sof_err  <= 1'b1;
            end
        end
    end

endmodule : camera_capture_ctrl
`default_nettype wire

// File: tb/tb_camera_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_camera_capture_ctrl
//  Description : Self-checking bench for camera_capture_ctrl on a 4x2 image.
//                A frame-position reference model predicts every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_camera_capture_ctrl;

    localparam int c_W  = 4;
    localparam int c_H  = 2;
    localparam int c_N  = c_W * c_H;
    localparam int c_DW = 24;
    localparam int c_AW = 18;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start, continuous, abort, cam_sof, cam_valid, wr_ready;
    logic [c_DW-1:0] cam_data;
    logic            wr_en, busy, frame_done, overflow, sof_err;
    logic [c_AW-1:0] wr_addr;
    logic [c_DW-1:0] wr_data;
    logic [7:0]      frame_count;

    always #5 clk = ~clk;

    camera_capture_ctrl #(
        .IMG_W  (c_W),
        .IMG_H  (c_H),
        .DATA_W (c_DW),
        .ADDR_W (c_AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .cam_sof     (cam_sof),
        .cam_data    (cam_data),
        .cam_valid   (cam_valid),
        .wr_ready    (wr_ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .sof_err     (sof_err),
        .frame_count (frame_count)
    );

    int n_chk = 0;
    int n_bad = 0;
    int obs_wr = 0;
    int obs_fd = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: m_pos is the frame index of the next expected pixel,
    // -1 while waiting for SOF, c_N once the frame has been fully received.
    bit            m_busy, m_cont, m_ovf, m_serr;
    int            m_pos;
    int            m_fc;
    bit            e_wr, e_fd;
    int            e_addr;
    logic [c_DW-1:0] e_data;

    task automatic model_reset();
        m_busy = 0; m_cont = 0; m_ovf = 0; m_serr = 0;
        m_pos = -1; m_fc = 0; e_wr = 0; e_fd = 0; e_addr = 0; e_data = '0;
    endtask

    task automatic model_step();
        int idx;
        e_wr = 0;
        e_fd = 0;
        if (abort) begin
            m_busy = 0;
            m_pos  = -1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_pos = -1; m_cont = continuous; m_ovf = 0; m_serr = 0;
            end
        end else if (m_pos == c_N) begin
            e_fd = 1;
            m_fc = (m_fc + 1) % 256;
            m_pos = -1;
            if (!m_cont) m_busy = 0;
        end else if (cam_valid) begin
            if (cam_sof) begin
                if (m_pos >= 0) m_serr = 1;
                idx = 0;
            end else begin
                idx = m_pos;
            end
            if (idx >= 0) begin
                if (wr_ready) begin
                    e_wr = 1; e_addr = idx; e_data = cam_data;
                end else begin
                    m_ovf = 1;
                end
                m_pos = idx + 1;
            end
        end
    endtask

    task automatic check_outputs();
        chk("wr_en", wr_en, e_wr);
        if (e_wr) begin
            chk("wr_addr", wr_addr, e_addr);
            chk("wr_data", wr_data, e_data);
        end
        chk("frame_done", frame_done, e_fd);
        chk("busy", busy, m_busy);
        chk("overflow", overflow, m_ovf);
        chk("sof_err", sof_err, m_serr);
        chk("frame_count", frame_count, m_fc);
        if (wr_en) obs_wr++;
        if (frame_done) obs_fd++;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit s, input logic [c_DW-1:0] d, input bit rdy,
                         input bit st, input bit ct, input bit ab);
        cam_valid = v; cam_sof = s; cam_data = d; wr_ready = rdy;
        start = st; continuous = ct; abort = ab;
        cycle();
        start = 0;
        abort = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, c_DW'($urandom), 1, 0, 0, 0);
    endtask

    task automatic frame(input bit ct, input int bad_ready_idx);
        for (int k = 0; k < c_N; k++)
            drive(1, k == 0, c_DW'($urandom), k != bad_ready_idx, 0, ct, 0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        #2;
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_wr_data"}, wr_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_sof_err"}, sof_err, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
        model_reset();
        cam_valid = 0; cam_sof = 0; start = 0; abort = 0; continuous = 0; wr_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 1; start = 0; continuous = 0; abort = 0;
        cam_sof = 0; cam_valid = 0; wr_ready = 1; cam_data = '0;
        #1;
        do_reset("rst");

        // 1: single frame, pixels 1..8, no back-pressure
        obs_wr = 0; obs_fd = 0;
        drive(0, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < c_N; k++) drive(1, k == 0, c_DW'(k + 1), 1, 0, 0, 0);
        idle(3);
        chk("t1_writes", obs_wr, 8);
        chk("t1_frames", obs_fd, 1);
        chk("t1_fc", frame_count, 1);
        chk("t1_busy", busy, 0);

        // 2: pixels before SOF are discarded
        obs_wr = 0; obs_fd = 0;
        drive(0, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 0, c_DW'($urandom), 1, 0, 0, 0);
        chk("t2_no_early_write", obs_wr, 0);
        frame(0, -1);
        idle(3);
        chk("t2_writes", obs_wr, 8);
        chk("t2_fc", frame_count, 2);

        // 3: back-pressure on the third pixel drops it but the frame completes
        obs_wr = 0; obs_fd = 0;
        drive(0, 0, 0, 1, 1, 0, 0);
        frame(0, 2);
        idle(3);
        chk("t3_writes", obs_wr, 7);
        chk("t3_overflow", overflow, 1);
        chk("t3_frames", obs_fd, 1);

        // 4: continuous mode, two frames back to back, then abort
        obs_wr = 0; obs_fd = 0;
        drive(0, 0, 0, 1, 1, 1, 0);
        frame(0, -1);
        idle(2);
        frame(1, -1);
        idle(2);
        chk("t4_busy", busy, 1);
        chk("t4_frames", obs_fd, 2);
        chk("t4_fc", frame_count, 5);
        drive(0, 0, 0, 1, 0, 0, 1);
        chk("t4_abort_busy", busy, 0);

        // 5: SOF at the fifth pixel restarts the frame
        obs_wr = 0; obs_fd = 0;
        drive(0, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) drive(1, k == 0, c_DW'($urandom), 1, 0, 0, 0);
        frame(0, -1);
        idle(3);
        chk("t5_sof_err", sof_err, 1);
        chk("t5_frames", obs_fd, 1);
        chk("t5_fc", frame_count, 6);

        // 6: abort at the fourth pixel, then reset in the middle of a frame
        obs_wr = 0; obs_fd = 0;
        drive(0, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, k == 0, c_DW'($urandom), 1, 0, 0, 0);
        drive(1, 0, c_DW'($urandom), 1, 0, 0, 1);
        chk("t6_abort_wr_en", wr_en, 0);
        chk("t6_abort_busy", busy, 0);
        idle(3);
        chk("t6_fc", frame_count, 6);
        chk("t6_frames", obs_fd, 0);
        drive(0, 0, 0, 1, 1, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, k == 0, c_DW'($urandom), 1, 0, 0, 0);
        do_reset("mid_rst");

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            bit v;
            v = ($urandom % 100) < 65;
            drive(v,
                  v ? (($urandom % 10) == 0) : (($urandom % 4) == 0),
                  c_DW'($urandom),
                  ($urandom % 100) < 88,
                  ($urandom % 100) < 6,
                  1'($urandom % 2),
                  ($urandom % 100) < 2);
            if (i == 1500) do_reset("rnd_rst");
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_camera_capture_ctrl
`default_nettype wire
